ifetch_stage: RTL and testbench
===============================

// Module: ifetch_stage
// PURPOSE
//  Instruction-fetch stage directly downstream of the PC register. Issues each PC
//  as a request to instruction memory and tracks in-flight requests. Pairs in-order
//  responses with their PC in a small queue and hands {instr, pc, pc+4} to decode
//  over a valid/ready handshake.
//  Drives stall_pc back to the PC register; the PC advances only when its value was
//  accepted or a redirect (flush) is in progress.
// PARAMETERS
//  DEPTH   4   queue entries plus in-flight requests; power of 2, >=2
//  CNT_W   3   counter width, = log2(DEPTH)+1
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-high reset
//  pc              in   32  current PC from the PC register
//  stall_pc        out  1   hold the PC register this cycle
//  flush           in   1   redirect from a later stage; discard all wrong-path work
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  word-aligned fetch address {pc[31:2],2'b00}
//  imem_req_ready  in   1   memory accepts the request this cycle
//  imem_resp_valid in   1   response data valid; in order; no backpressure
//  imem_resp_data  in   32  instruction word
//  id_valid        out  1   decode-side entry valid
//  id_instr        out  32  instruction at the queue head
//  id_pc           out  32  PC of that instruction
//  id_pc4          out  32  id_pc + 4, modulo 2^32
//  id_ready        in   1   decode consumes the head this cycle
// BEHAVIOUR
//  - Queue entry: {pc, instr, filled}.
//    - Allocated at issue with filled=0.
//    - The oldest unfilled entry is filled on each non-killed response.
//  - count = allocated entries; kill = responses still owed to flushed requests.
//  - Request fire is req_valid & req_ready.
//    - req_valid = !flush & (count + kill < DEPTH).
//    - On fire, the entry is allocated with pc.
//  - stall_pc = !fire & !flush. While flush=1 the PC must load the redirect target.
//  - Response handling:
//    - kill>0: data dropped, kill decrements.
//    - Otherwise: fills the oldest unfilled entry.
//    - A response with no outstanding request is a protocol error; covered by an assertion.
//  - id_valid = head entry allocated & filled. Pop on id_valid & id_ready.
//  - Latency: a response arriving in cycle N is visible on id_* in cycle N+1 (registered).
//  - Same-cycle alloc + pop: count unchanged; both pointers advance; wrap modulo DEPTH.
//  - A response can fill the head entry in the same cycle it pops only if the head
//    was already filled. No bypass from imem_resp to id_*.
//  - Full (count+kill == DEPTH): req_valid=0, stall_pc=1 unless flush.
//  - Empty: id_valid=0; id_instr/id_pc hold their last values (don't-care).
//  - Flush, registered effect at the next edge:
//    - All entries are invalidated; pointers and count go to 0.
//    - kill += number of unfilled allocated entries.
//    - If a response arrives in the flush cycle it is dropped, even if kill was 0.
//    - id_valid=0 in the following cycle.
//    - Flush has priority over id_ready; a pop in the flush cycle is ignored.
//  - Reset values:
//    - Pointers, count and kill = 0.
//    - id_valid=0, imem_req_valid=0 during rst; data outputs 0.
//    - stall_pc=1 during rst.
//  - Reset asserted mid-operation: all state clears; outstanding memory responses after
//    reset are the memory's responsibility (memory is reset together).
//  - Deassert timing: the first request (addr 0x0000_0000) can fire in the first cycle
//    after rst deasserts.
// STRUCTURE
//  - Constants go in the shared CPU defines header: RESET_PC=32'h0, INSTR_W=32, NOP=32'h0.
//  - One sub-module, fetch_queue:
//    - circular buffer of DEPTH entries;
//    - alloc/fill/pop ports and a clear input;
//    - head, fill and tail pointers.
//  - The top level holds the kill counter, the handshake logic and the pc+4 adder.
// TESTING
//  1 Memory always ready, 1-cycle response, id_ready=1 -> pc 0,4,8... fetched back-to-back;
//    id_pc4 = id_pc+4; stall_pc=0 steady.
//  2 id_ready=0 for 10 cycles -> exactly DEPTH=4 requests issued; then req_valid=0 and
//    stall_pc=1; no entry lost when id_ready returns.
//  3 imem_req_ready=0 for 3 cycles -> stall_pc=1 and imem_req_addr held at the same pc;
//    fires on cycle 4.
//  4 Flush with 2 requests in flight, resp latency 3, redirect pc=0x100:
//    - both old responses are dropped;
//    - the first id_valid carries id_pc=0x100.
//  5 Flush in the same cycle as a response, a pop and a full queue -> all dropped;
//    count=0; id_valid=0 next cycle.
//  6 rst asserted with 3 entries queued -> id_valid=0, req_valid=0, stall_pc=1
//    immediately. After release the first request address is 0x0000_0000.
//    Also check pointer wrap over 3*DEPTH pops.

Source files
------------

// File: rtl/ifetch_stage_pkg.sv
// Shared fetch-stage constants and the fetch-queue entry type.
package ifetch_stage_pkg;

  localparam int              INSTR_W  = 32;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP   = 32'h0000_0000;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_CNT_W = 3;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
    logic               filled;
  } fq_entry_t;

endpackage

// File: rtl/ifetch_stage_fetch_queue.sv
// Circular buffer pairing issued PCs with in-order memory responses.
// Entries are allocated at the tail when issued, filled in age order at the
// fill pointer, and popped from the head once filled.
module ifetch_stage_fetch_queue
  import ifetch_stage_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int CNT_W = FQ_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               alloc_i,
  input  logic [31:0]        alloc_pc_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_instr_i,
  input  logic               pop_i,
  output logic               head_valid_o,
  output logic [31:0]        head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [CNT_W-1:0]   count_o,
  output logic [CNT_W-1:0]   unfilled_o
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fq_entry_t        entry_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] unfilled_q, unfilled_d;
  logic             alloc_ok, fill_ok, pop_ok;

  // Head is poppable only when it exists and its response has arrived.
  assign head_valid_o = (count_q != '0) && entry_q[head_q].filled;
  assign head_pc_o    = entry_q[head_q].pc;
  assign head_instr_o = entry_q[head_q].instr;
  assign count_o      = count_q;
  assign unfilled_o   = unfilled_q;

  assign alloc_ok = alloc_i && (count_q != FULL);
  assign fill_ok  = fill_i && (unfilled_q != '0);
  assign pop_ok   = pop_i && head_valid_o;

  // Pointer and occupancy next-state; clear discards every entry at once.
  always_comb begin
    head_d     = head_q + PTR_W'(pop_ok);
    tail_d     = tail_q + PTR_W'(alloc_ok);
    fill_d     = fill_q + PTR_W'(fill_ok);
    count_d    = count_q + CNT_W'(alloc_ok) - CNT_W'(pop_ok);
    unfilled_d = unfilled_q + CNT_W'(alloc_ok) - CNT_W'(fill_ok);
    if (clear_i) begin
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  // Entry storage: allocate at the tail, fill the oldest unfilled entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '{pc: RESET_PC, instr: NOP, filled: 1'b0};
      end
    end else if (!clear_i) begin
      if (alloc_ok) begin
        entry_q[tail_q] <= '{pc: alloc_pc_i, instr: NOP, filled: 1'b0};
      end
      if (fill_ok) begin
        entry_q[fill_q].instr  <= fill_instr_i;
        entry_q[fill_q].filled <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: issues the current PC to instruction memory, pairs
// in-order responses with their PC and presents {instr, pc, pc+4} to decode.
// A redirect (flush) discards all queued work; responses still owed to the
// discarded requests are counted in kill_q and dropped when they arrive.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int CNT_W = FQ_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  output logic               stall_pc,
  input  logic               flush,
  output logic               imem_req_valid,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc4,
  input  logic               id_ready
);

  localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] kill_q, kill_d;
  logic [CNT_W-1:0] count, unfilled;
  logic [CNT_W:0]   occupancy;
  logic             fire, fill, owed;

  // Queue entries and killed responses share the same DEPTH slots.
  assign occupancy      = {1'b0, count} + {1'b0, kill_q};
  assign imem_req_valid = !rst && !flush && (occupancy < CAP);
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign fire           = imem_req_valid && imem_req_ready;
  assign stall_pc       = rst || (!fire && !flush);

  assign fill = imem_resp_valid && !flush && (kill_q == '0);
  assign owed = (kill_q != '0) || (unfilled != '0);

  assign id_pc4 = id_pc + 32'd4;

  ifetch_stage_fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fetch_queue (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (flush),
    .alloc_i      (fire),
    .alloc_pc_i   (pc),
    .fill_i       (fill),
    .fill_instr_i (imem_resp_data),
    .pop_i        (id_ready),
    .head_valid_o (id_valid),
    .head_pc_o    (id_pc),
    .head_instr_o (id_instr),
    .count_o      (count),
    .unfilled_o   (unfilled)
  );

  // Kill accounting: a flush converts every unfilled entry into an owed drop;
  // a response landing in the flush cycle retires one owed response itself.
  always_comb begin
    kill_d = kill_q;
    if (flush) begin
      kill_d = kill_q + unfilled - CNT_W'(imem_resp_valid && owed);
    end else if (imem_resp_valid && (kill_q != '0)) begin
      kill_d = kill_q - CNT_W'(1);
    end
  end

  // Kill counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kill_q <= '0;
    end else begin
      kill_q <= kill_d;
    end
  end

  // Every response must belong to an outstanding request, live or killed.
  assert property (@(posedge clk) disable iff (rst) imem_resp_valid |-> owed);

endmodule

// File: tb/tb_ifetch_stage.sv
// Testbench for ifetch_stage: models the PC register and an in-order memory
// with variable latency; a monitor scoreboards every fetch and every pop.
module tb_ifetch_stage;
  import ifetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        stall_pc, flush;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc4;

  ifetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .stall_pc        (stall_pc),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc4          (id_pc4),
    .id_ready        (id_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  rsp_t mem_q[$];
  int   cyc = 0, lat = 1, last_due = 0, n_fire = 0, n_pop = 0;
  logic [31:0] exp_addr = RESET_PC, flush_tgt = 32'h0, pc_nx = RESET_PC, rd_nx = 32'h0;
  logic        rv_nx = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endfunction

  // Monitor / scoreboard: samples mid-cycle, tracks issued fetches, checks pops,
  // and computes the PC register and memory response for the next cycle.
  initial begin : monitor
    exp_t e;
    int   d_cyc;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        mem_q.delete();
        exp_addr = RESET_PC;
        pc_nx    = RESET_PC;
        rv_nx    = 1'b0;
        rd_nx    = 32'h0;
        last_due = 0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          chk32("req_addr", imem_req_addr, exp_addr);
          n_fire++;
          exp_q.push_back('{pc: exp_addr, instr: mem_word(exp_addr)});
          d_cyc = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
          last_due = d_cyc;
          mem_q.push_back('{due: d_cyc, data: mem_word(imem_req_addr)});
          exp_addr = exp_addr + 32'd4;
        end
        if (flush) begin
          exp_q.delete();
          exp_addr = flush_tgt;
          pc_nx    = flush_tgt;
        end else begin
          if (id_valid && id_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL id_unexpected: got entry pc %h expected no entry", id_pc);
            end else begin
              e = exp_q.pop_front();
              chk32("id_pc", id_pc, e.pc);
              chk32("id_instr", id_instr, e.instr);
              chk32("id_pc4", id_pc4, e.pc + 32'd4);
            end
          end
          pc_nx = stall_pc ? pc : pc + 32'd4;
        end
        if (mem_q.size() != 0 && mem_q[0].due <= cyc + 1) begin
          rv_nx = 1'b1;
          rd_nx = mem_q[0].data;
          void'(mem_q.pop_front());
        end else begin
          rv_nx = 1'b0;
          rd_nx = 32'hDEAD_BEEF;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    pc              = pc_nx;
    imem_resp_valid = rv_nx;
    imem_resp_data  = rd_nx;
  endtask

  task automatic tick(input logic rdy, input logic idr, input logic fl);
    step();
    imem_req_ready = rdy;
    id_ready       = idr;
    flush          = fl;
  endtask

  task automatic wait_first(input string name, input logic [31:0] tgt);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      if (id_valid) begin
        found = 1'b1;
        chk32(name, id_pc, tgt);
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: no id_valid within 20 cycles, expected pc %h", name, tgt);
    end
  endtask

  initial begin : main
    logic [31:0] hold;
    int          f0, p0;
    bit          full_seen;
    rst = 1'b1; pc = RESET_PC; flush = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; id_ready = 1'b0;
    #1;
    chk1("rst_id_valid", id_valid, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_stall", stall_pc, 1'b1);
    chk32("rst_id_pc", id_pc, 32'h0);
    chk32("rst_id_instr", id_instr, 32'h0);
    repeat (3) step();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; flush = 1'b0; lat = 1;
    @(negedge clk);
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk32("first_req_addr", imem_req_addr, RESET_PC);

    // back-to-back streaming
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk1("t1_stall", stall_pc, 1'b0);
    end

    // decode stalled: only DEPTH requests issue
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    f0 = n_fire;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk1("t2_full_req_valid", imem_req_valid, 1'b0);
    chk1("t2_full_stall", stall_pc, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    chk32("t2_fires", 32'(n_fire - f0), 32'd4);
    repeat (10) tick(1'b1, 1'b1, 1'b0);

    // memory not ready for 3 cycles
    tick(1'b0, 1'b1, 1'b0);
    hold = exp_addr;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk1("t3_stall", stall_pc, 1'b1);
      chk1("t3_req_valid", imem_req_valid, 1'b1);
      chk32("t3_addr_hold", imem_req_addr, hold);
    end
    tick(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk1("t3_fire_stall", stall_pc, 1'b0);
    chk32("t3_fire_addr", imem_req_addr, hold);

    // flush with two requests in flight, latency 3
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    lat = 3;
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    flush_tgt = 32'h0000_0100;
    @(negedge clk);
    chk1("t4_flush_stall", stall_pc, 1'b0);
    chk1("t4_flush_req_valid", imem_req_valid, 1'b0);
    wait_first("t4_first_pc", 32'h0000_0100);

    // flush with a full queue, a response and a pop in the same cycle
    repeat (6) tick(1'b0, 1'b1, 1'b0);
    lat = 2;
    full_seen = 1'b0;
    for (int i = 0; i < 12 && !full_seen; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (!imem_req_valid) full_seen = 1'b1;
    end
    chk1("t5_full_reached", full_seen, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    flush_tgt = 32'h0000_0200;
    @(negedge clk);
    chk1("t5_head_valid", id_valid, 1'b1);
    chk1("t5_flush_req_valid", imem_req_valid, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk1("t5_id_valid_after", id_valid, 1'b0);
    wait_first("t5_first_pc", 32'h0000_0200);

    // reset with three entries queued
    repeat (6) tick(1'b0, 1'b1, 1'b0);
    lat = 1;
    repeat (3) tick(1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("t6_pre_id_valid", id_valid, 1'b1);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk1("t6_rst_id_valid", id_valid, 1'b0);
    chk1("t6_rst_req_valid", imem_req_valid, 1'b0);
    chk1("t6_rst_stall", stall_pc, 1'b1);
    repeat (2) step();
    step();
    rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; flush = 1'b0;
    @(negedge clk);
    chk1("t6_first_req_valid", imem_req_valid, 1'b1);
    chk32("t6_first_req_addr", imem_req_addr, RESET_PC);
    tick(1'b1, 1'b1, 1'b0);
    p0 = n_pop;
    repeat (20) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk1("wrap_pops", (n_pop - p0) >= 12, 1'b1);

    // randomized traffic with occasional redirects
    p0 = n_pop;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'(($urandom_range(0, 24) == 0) || (i == 100)));
      lat = $urandom_range(1, 4);
      flush_tgt = (i == 100) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
    end
    tick(1'b0, 1'b1, 1'b0);
    chk1("rand_pops", (n_pop - p0) > 50, 1'b1);
    for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_q.size() != 0); i++) begin
      tick(1'b0, 1'b1, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b0);
    chk32("drain_left", 32'(exp_q.size() + mem_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
